pipemem_stage: RTL and testbench

- Memory stage of the 5-stage pipelined CPU, directly downstream of the execute stage.
- Contains the EX/MEM pipeline register, which captures the execute result, store data, destination register and control bits.
- Runs a req/ack handshake FSM toward the data memory bus and stalls the upstream pipeline while an access is outstanding.
- Presents load data and the ALU result to the MEM/WB register. A watchdog aborts accesses that never complete.

---
 rtl/pipemem_stage.sv | 117 +++++++++++
 tb/tb_pipemem_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipemem_stage.sv
// Memory stage: EX/MEM register, data-bus req/ack FSM and access watchdog.
// Stalls the upstream pipeline while a load or store is outstanding.
module pipemem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    output logic        mwreg,
    output logic        mm2reg,
    output logic [4:0]  mrn,
    output logic [31:0] malu,
    output logic [31:0] mmo,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } ex_mem_t;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    ex_mem_t    exm_q, exm_d;
    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err_q, bus_err_d;
    logic       access;
    logic       timeout;

    assign access    = exm_q.m2reg | exm_q.wmem;
    assign dmem_req  = access;
    assign timeout   = dmem_req & ~dmem_ack & (wait_cnt_q == CNT_MAX);
    assign mem_stall = dmem_req & ~dmem_ack & ~timeout;

    assign dmem_we    = exm_q.wmem;
    assign dmem_addr  = exm_q.alu;
    assign dmem_wdata = exm_q.b;

    // An aborted access must not write a stale register in WB.
    assign mwreg   = exm_q.wreg & ~timeout;
    assign mm2reg  = exm_q.m2reg;
    assign mrn     = exm_q.rn;
    assign malu    = exm_q.alu;
    assign mmo     = (dmem_ack & dmem_req & ~exm_q.wmem) ? dmem_rdata : '0;
    assign bus_err = bus_err_q;

    always_comb begin
        exm_d = exm_q;
        if (!mem_stall) begin
            exm_d.wreg  = ewreg;
            exm_d.m2reg = em2reg;
            exm_d.wmem  = ewmem;
            exm_d.alu   = ealu;
            exm_d.b     = eb;
            exm_d.rn    = ern;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q | timeout;
        unique case (state_q)
            S_IDLE: begin
                if (access && !dmem_ack && !timeout) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            S_WAIT: begin
                if (dmem_ack || timeout) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exm_q      <= '0;
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
            bus_err_q  <= 1'b0;
        end else begin
            exm_q      <= exm_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_pipemem_stage.sv
// Bench for pipemem_stage: directed scenarios plus random traffic
// checked against a cycle-level model of the memory stage.
module tb_pipemem_stage;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ewreg = 1'b0, em2reg = 1'b0, ewmem = 1'b0;
    logic [31:0] ealu = '0, eb = '0;
    logic [4:0]  ern = '0;
    logic        mwreg, mm2reg, mem_stall, bus_err;
    logic [4:0]  mrn;
    logic [31:0] malu, mmo;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference: contents of the stage register and cycles outstanding.
    logic        r_wreg, r_m2reg, r_wmem, r_err;
    logic [31:0] r_alu, r_b;
    logic [4:0]  r_rn;
    int          r_cnt;
    logic        e_stall, e_to;

    pipemem_stage #(.TIMEOUT(T)) dut (
        .clock(clock), .resetn(resetn),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealu(ealu), .eb(eb), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu),
        .mmo(mmo), .mem_stall(mem_stall), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        r_wreg = 0; r_m2reg = 0; r_wmem = 0; r_err = 0;
        r_alu = '0; r_b = '0; r_rn = '0; r_cnt = 0;
        e_stall = 0; e_to = 0;
    endtask

    task automatic set_ex(input logic w, input logic m, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rn);
        ewreg = w; em2reg = m; ewmem = s;
        ealu = a; eb = b; ern = rn;
    endtask

    task automatic probe(input logic ack, input logic [31:0] rd);
        logic acc, to, st;
        logic [31:0] exp_mmo;
        dmem_ack = ack;
        dmem_rdata = rd;
        #1;
        acc = r_m2reg | r_wmem;
        to = acc && !ack && (r_cnt == T - 1);
        st = acc && !ack && !to;
        exp_mmo = (acc && ack && !r_wmem) ? rd : 32'h0;
        e_stall = st;
        e_to = to;
        chk("req", {31'b0, dmem_req}, {31'b0, acc});
        chk("stall", {31'b0, mem_stall}, {31'b0, st});
        chk("mwreg", {31'b0, mwreg}, {31'b0, r_wreg & ~to});
        chk("mm2reg", {31'b0, mm2reg}, {31'b0, r_m2reg});
        chk("mrn", {27'b0, mrn}, {27'b0, r_rn});
        chk("malu", malu, r_alu);
        chk("addr", dmem_addr, r_alu);
        chk("we", {31'b0, dmem_we}, {31'b0, r_wmem});
        chk("wdata", dmem_wdata, r_b);
        chk("mmo", mmo, exp_mmo);
        chk("bus_err", {31'b0, bus_err}, {31'b0, r_err});
    endtask

    task automatic advance();
        @(posedge clock);
        if (e_to) r_err = 1;
        r_cnt = e_stall ? r_cnt + 1 : 0;
        if (!e_stall) begin
            r_wreg = ewreg; r_m2reg = em2reg; r_wmem = ewmem;
            r_alu = ealu; r_b = eb; r_rn = ern;
        end
        #1;
    endtask

    initial begin
        int n;
        model_reset();
        #3;
        probe(0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;

        // zero-wait load
        set_ex(1, 1, 0, 32'h100, 32'h0, 5'd5);
        probe(0, 0); advance();
        set_ex(0, 0, 0, 0, 0, 0);
        probe(1, 32'hDEADBEEF);
        chk("ld_mmo", mmo, 32'hDEADBEEF);
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_we", {31'b0, dmem_we}, 32'h0);
        chk("ld_stall", {31'b0, mem_stall}, 32'h0);
        chk("ld_mwreg", {31'b0, mwreg}, 32'h1);
        chk("ld_mrn", {27'b0, mrn}, 32'h5);
        advance();

        // store acked after 3 cycles, inputs scrambled during stall
        set_ex(0, 0, 1, 32'h40, 32'h12345678, 5'd0);
        probe(0, 0); advance();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            set_ex(1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom, $urandom, 5'($urandom));
            probe(0, 0);
            if (mem_stall) n++;
            advance();
        end
        set_ex(0, 0, 0, 0, 0, 0);
        probe(1, 32'h0);
        chk("st_we", {31'b0, dmem_we}, 32'h1);
        chk("st_wdata", dmem_wdata, 32'h12345678);
        chk("st_hold_addr", malu, 32'h40);
        chk("st_stall_end", {31'b0, mem_stall}, 32'h0);
        chk("st_stall_cycles", n, 32'd3);
        advance();

        // back-to-back zero-wait load then store
        set_ex(1, 1, 0, 32'h200, 32'h0, 5'd3);
        probe(0, 0); advance();
        set_ex(0, 0, 1, 32'h204, 32'hA5A5A5A5, 5'd0);
        probe(1, 32'h11112222);
        chk("b2b_addr0", dmem_addr, 32'h200);
        chk("b2b_stall0", {31'b0, mem_stall}, 32'h0);
        advance();
        set_ex(0, 0, 0, 0, 0, 0);
        probe(1, 32'h0);
        chk("b2b_addr1", dmem_addr, 32'h204);
        chk("b2b_req1", {31'b0, dmem_req}, 32'h1);
        chk("b2b_stall1", {31'b0, mem_stall}, 32'h0);
        advance();

        // load never acked: watchdog abort
        set_ex(1, 1, 0, 32'h300, 32'h0, 5'd7);
        probe(0, 0); advance();
        set_ex(0, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            probe(0, 0);
            if (mem_stall) n++;
            advance();
        end
        probe(0, 32'h0);
        chk("to_stall", {31'b0, mem_stall}, 32'h0);
        chk("to_mwreg", {31'b0, mwreg}, 32'h0);
        chk("to_mmo", mmo, 32'h0);
        chk("to_err_pre", {31'b0, bus_err}, 32'h0);
        advance();
        chk("to_err", {31'b0, bus_err}, 32'h1);
        chk("to_stall_cycles", n, 32'd3);
        set_ex(1, 1, 0, 32'h400, 32'h0, 5'd8);
        probe(0, 0); advance();
        set_ex(0, 0, 0, 0, 0, 0);
        probe(1, 32'hCAFEF00D);
        chk("after_to_mmo", mmo, 32'hCAFEF00D);
        advance();

        // plain ALU op with spurious ack
        set_ex(1, 0, 0, 32'h7, 32'h0, 5'd9);
        probe(0, 0); advance();
        set_ex(0, 0, 0, 0, 0, 0);
        probe(1, $urandom);
        chk("alu_req", {31'b0, dmem_req}, 32'h0);
        chk("alu_stall", {31'b0, mem_stall}, 32'h0);
        chk("alu_malu", malu, 32'h7);
        chk("alu_mrn", {27'b0, mrn}, 32'd9);
        chk("alu_mwreg", {31'b0, mwreg}, 32'h1);
        chk("alu_mmo", mmo, 32'h0);
        advance();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            set_ex(1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom, $urandom, 5'($urandom));
            probe($urandom_range(0, 2) == 0, $urandom);
            advance();
        end

        // async reset in the middle of a wait
        set_ex(1, 1, 0, 32'h500, 32'h0, 5'd4);
        probe(0, 0); advance();
        set_ex(0, 0, 0, 0, 0, 0);
        probe(0, 0); advance();
        probe(0, 0); advance();
        chk("rst_pre_req", {31'b0, dmem_req}, 32'h1);
        chk("rst_pre_err", {31'b0, bus_err}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_stall", {31'b0, mem_stall}, 32'h0);
        chk("rst_mwreg", {31'b0, mwreg}, 32'h0);
        chk("rst_mm2reg", {31'b0, mm2reg}, 32'h0);
        chk("rst_mrn", {27'b0, mrn}, 32'h0);
        chk("rst_malu", malu, 32'h0);
        chk("rst_mmo", mmo, 32'h0);
        chk("rst_err", {31'b0, bus_err}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
